// File: rtl/serial_tank.sv
// serial_tank: WORDS x WIDTH-bit serial delay-line store, LSB-first, one bit
// per clock, with per-word load/clear/recirculate, one-digit left shift on
// the write path, and a registered sign test on the selected word's MSB.
module serial_tank #(
  parameter int WIDTH  = 36,
  parameter int WORDS  = 1,
  parameter int WSEL_W = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      din,
  input  logic                      load,
  input  logic                      recirc,
  input  logic                      shift,
  input  logic [WSEL_W-1:0]         word_sel,
  input  logic                      out_en,
  input  logic                      sign_req,
  output logic                      dout,
  output logic                      tap,
  output logic [$clog2(WIDTH)-1:0]  bit_pos,
  output logic [WSEL_W-1:0]         word_pos,
  output logic                      word_start,
  output logic                      sign_q,
  output logic                      sign_valid
);

  localparam int BP_W  = $clog2(WIDTH);
  localparam int NBITS = WORDS * WIDTH;
  localparam logic [BP_W-1:0]   BP_MAX = BP_W'(WIDTH - 1);
  localparam logic [WSEL_W-1:0] WP_MAX = WSEL_W'(WORDS - 1);

  logic [NBITS-1:0] store;
  logic             store_out;
  logic             sel;
  logic             ppi;
  logic             ppi_d;
  logic             wbit;

  // Oldest bit sits at index 0; new bits enter at the top.
  assign store_out  = store[0];
  assign tap        = ppi;
  assign dout       = ppi & out_en & sel;
  assign word_start = (bit_pos == '0);

  // Word selection and the bit fed back into the store.
  always_comb begin
    sel  = (WORDS == 1) ? 1'b1 : (word_pos == word_sel);
    ppi  = store_out;
    if (sel) ppi = (store_out & recirc) | (din & load);
    wbit = ppi;
    // Shifting writes the previous digit; digit 0 of the word gets a zero so
    // the MSB of the word never spills into the next word.
    if (shift && sel) wbit = (bit_pos == '0) ? 1'b0 : ppi_d;
  end

  // Delay line and one-digit delay used by the shift path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      store <= '0;
      ppi_d <= 1'b0;
    end else begin
      store <= {wbit, store[NBITS-1:1]};
      ppi_d <= ppi;
    end
  end

  // Digit and word position counters identifying store_out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_pos  <= '0;
      word_pos <= '0;
    end else if (bit_pos == BP_MAX) begin
      bit_pos <= '0;
      if (word_pos == WP_MAX) word_pos <= '0;
      else                    word_pos <= word_pos + WSEL_W'(1);
    end else begin
      bit_pos <= bit_pos + BP_W'(1);
    end
  end

  // Sign sample of the selected word on its MSB digit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sign_q     <= 1'b0;
      sign_valid <= 1'b0;
    end else begin
      sign_valid <= 1'b0;
      if ((bit_pos == BP_MAX) && sel && sign_req) begin
        sign_q     <= ppi;
        sign_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_tank.sv
// Testbench for serial_tank: a single-word and a four-word tank share the
// control inputs; each is checked every cycle against a word-array model.
module tb_serial_tank;

  logic       clk = 1'b0;
  logic       rst_n, din, load, recirc, shift, out_en, sign_req;
  logic [1:0] word_sel;

  logic       dout_a, tap_a, ws_a, sq_a, sv_a;
  logic [5:0] bp_a;
  logic [0:0] wp_a;
  logic       dout_b, tap_b, ws_b, sq_b, sv_b;
  logic [5:0] bp_b;
  logic [1:0] wp_b;

  int n_assert = 0;
  int n_fail   = 0;
  logic checking = 1'b0;
  logic last_dout [2];

  serial_tank #(.WIDTH(36), .WORDS(1), .WSEL_W(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .din(din), .load(load), .recirc(recirc),
    .shift(shift), .word_sel(word_sel[0:0]), .out_en(out_en),
    .sign_req(sign_req), .dout(dout_a), .tap(tap_a), .bit_pos(bp_a),
    .word_pos(wp_a), .word_start(ws_a), .sign_q(sq_a), .sign_valid(sv_a));

  serial_tank #(.WIDTH(36), .WORDS(4), .WSEL_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din), .load(load), .recirc(recirc),
    .shift(shift), .word_sel(word_sel), .out_en(out_en),
    .sign_req(sign_req), .dout(dout_b), .tap(tap_b), .bit_pos(bp_b),
    .word_pos(wp_b), .word_start(ws_b), .sign_q(sq_b), .sign_valid(sv_b));

  always #5 clk = ~clk;

  // Reference model: each tank is an array of words indexed by position.
  int          nw [2] = '{1, 4};
  logic [35:0] mm [2][4];
  int          mw [2];
  int          mb [2];
  logic        pd [2];
  logic        msq [2];
  logic        msv [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_sel(int i);
    return (nw[i] == 1) || (mw[i] == int'(word_sel));
  endfunction

  function automatic logic m_ppi(int i);
    logic so;
    so = mm[i][mw[i]][mb[i]];
    return m_sel(i) ? ((so & recirc) | (din & load)) : so;
  endfunction

  task automatic model_step(int i);
    logic p, s, wb;
    if (!rst_n) begin
      for (int w = 0; w < 4; w++) mm[i][w] = '0;
      mw[i] = 0; mb[i] = 0; pd[i] = 1'b0; msq[i] = 1'b0; msv[i] = 1'b0;
    end else begin
      p  = m_ppi(i);
      s  = m_sel(i);
      wb = (shift && s) ? ((mb[i] == 0) ? 1'b0 : pd[i]) : p;
      msv[i] = (mb[i] == 35) && s && sign_req;
      if (msv[i]) msq[i] = p;
      mm[i][mw[i]][mb[i]] = wb;
      pd[i] = p;
      if (mb[i] == 35) begin
        mb[i] = 0;
        mw[i] = (mw[i] + 1) % nw[i];
      end else begin
        mb[i] = mb[i] + 1;
      end
    end
  endtask

  // One clock: compare outputs mid-cycle, then advance DUT and model together.
  task automatic cycle();
    logic p, s;
    #2;
    if (checking) begin
      for (int i = 0; i < 2; i++) begin
        p = m_ppi(i);
        s = m_sel(i);
        chk(i == 0 ? "tap_a"  : "tap_b",  i == 0 ? tap_a  : tap_b,  p);
        chk(i == 0 ? "dout_a" : "dout_b", i == 0 ? dout_a : dout_b, p & out_en & s);
        chk(i == 0 ? "bpos_a" : "bpos_b", i == 0 ? bp_a : bp_b, mb[i]);
        chk(i == 0 ? "wpos_a" : "wpos_b", i == 0 ? 64'(wp_a) : 64'(wp_b), mw[i]);
        chk(i == 0 ? "wst_a"  : "wst_b",  i == 0 ? ws_a : ws_b, mb[i] == 0);
        chk(i == 0 ? "sq_a"   : "sq_b",   i == 0 ? sq_a : sq_b, msq[i]);
        chk(i == 0 ? "sv_a"   : "sv_b",   i == 0 ? sv_a : sv_b, msv[i]);
      end
    end
    last_dout[0] = dout_a;
    last_dout[1] = dout_b;
    @(posedge clk);
    model_step(0);
    model_step(1);
    if (!rst_n) checking = 1'b1;
    #1;
  endtask

  task automatic idle();
    din = 1'b0; load = 1'b0; recirc = 1'b1; shift = 1'b0;
    out_en = 1'b0; sign_req = 1'b0;
  endtask

  // Align to the start of word w of the four-word tank, then run one word
  // with the given controls, serialising data and collecting both douts.
  task automatic do_word(input int w, input logic [35:0] data,
                         input logic ld, input logic rc, input logic sh,
                         input logic oe, input logic sr,
                         output logic [35:0] ga, output logic [35:0] gb);
    int guard;
    idle();
    word_sel = 2'(w);
    guard = 0;
    while (!(mw[1] == w && mb[1] == 0) && guard < 200) begin
      cycle();
      guard++;
    end
    for (int b = 0; b < 36; b++) begin
      din = data[b]; load = ld; recirc = rc; shift = sh;
      out_en = oe; sign_req = sr;
      cycle();
      ga[b] = last_dout[0];
      gb[b] = last_dout[1];
    end
    idle();
  endtask

  task automatic rd(input int w, input logic [35:0] exp, input string tag);
    logic [35:0] ga, gb;
    do_word(w, '0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ga, gb);
    chk(tag, gb, exp);
  endtask

  initial begin
    logic [35:0] ga, gb;
    int ws_cnt;
    rst_n = 1'b0; word_sel = 2'd0;
    idle();
    @(posedge clk); #1;

    // Reset and idle circulation of an empty store
    cycle(); cycle();
    rst_n = 1'b1;
    chk("rst_bpos", bp_b, 0);
    chk("rst_wst", ws_b, 1);
    ws_cnt = 0;
    for (int k = 0; k < 288; k++) begin
      cycle();
      if (ws_b) ws_cnt++;
    end
    chk("wst_count", ws_cnt, 8);

    // Load and recirculate
    do_word(0, 36'h000000005, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ga, gb);
    for (int r = 0; r < 3; r++) begin
      do_word(0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ga, gb);
      chk("recirc_a", ga, 36'h000000005);
      chk("recirc_b", gb, 36'h000000005);
    end

    // Shift, MSB discarded
    do_word(0, 36'h800000003, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ga, gb);
    do_word(0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ga, gb);
    do_word(0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ga, gb);
    chk("shift_a", ga, 36'h000000006);
    chk("shift_b", gb, 36'h000000006);

    // Multi-word load and selective clear
    do_word(0, 36'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ga, gb);
    do_word(1, 36'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ga, gb);
    do_word(2, 36'hA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ga, gb);
    do_word(3, 36'h4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ga, gb);
    do_word(1, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ga, gb);
    rd(0, 36'h1, "mw_w0");
    rd(1, 36'h0, "mw_w1");
    rd(2, 36'hA, "mw_w2");
    rd(3, 36'h4, "mw_w3");

    // Superposition of recirculated and loaded data
    do_word(0, 36'h3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ga, gb);
    do_word(0, 36'h4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ga, gb);
    rd(0, 36'h7, "superpos");

    // Sign test, negative then positive word
    do_word(2, 36'h800000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ga, gb);
    do_word(2, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, ga, gb);
    chk("sign1_valid", sv_b, 1);
    chk("sign1_q", sq_b, 1);
    cycle();
    chk("sign1_pulse", sv_b, 0);
    chk("sign1_hold", sq_b, 1);
    do_word(0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, ga, gb);
    chk("sign0_valid", sv_b, 1);
    chk("sign0_q", sq_b, 0);

    // Reset in the middle of word 1
    idle();
    word_sel = 2'd1;
    for (int g = 0; g < 200 && !(mw[1] == 1 && mb[1] == 17); g++) cycle();
    chk("pre_rst_bpos", bp_b, 17);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("midrst_bpos", bp_b, 0);
    chk("midrst_wpos", wp_b, 0);
    for (int w = 0; w < 4; w++) rd(w, '0, "midrst_word");

    // Randomised controls against the model
    for (int k = 0; k < 3000; k++) begin
      din      = 1'($urandom);
      load     = ($urandom_range(0, 3) == 0);
      recirc   = ($urandom_range(0, 3) != 0);
      shift    = ($urandom_range(0, 5) == 0);
      out_en   = 1'($urandom);
      sign_req = 1'($urandom);
      word_sel = 2'($urandom);
      rst_n    = ($urandom_range(0, 299) != 0);
      cycle();
    end
    rst_n = 1'b1;
    idle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_tank.md
# serial_tank

Parametrised serial delay-line store ("tank") for the EDSAC computer datapath. It holds WORDS words of WIDTH bits, circulating LSB-first, one bit per clock. Per word it supports selective load, clear, recirculate and a one-digit left shift on the path into the store, plus a registered sign test. It generalises the single-word multiplicand tank so that the same block can serve as the multiplicand, the multiplier and short/long tanks.

## Interface

- WIDTH, 36, bits per word (minor cycle length in clocks); ≥ 2
- WORDS, 1, words held in the tank; ≥ 1
- WSEL_W, 1, width of word_sel/word_pos; must equal max(1, clog2(WORDS))

- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  synchronous, active-low reset
- din  in  1  serial data in (Main Input Bus bit)
- load  in  1  admit din into selected word
- recirc  in  1  recirculate selected word; 0 clears it
- shift  in  1  left-shift selected word by one digit as it re-enters the store
- word_sel  in  WSEL_W  word affected by load/recirc/shift/out_en/sign_req
- out_en  in  1  gate selected word onto dout
- sign_req  in  1  request sign sample of selected word
- dout  out  1  gated serial output
- tap  out  1  raw circulating bit (ppi) of the current word
- bit_pos  out  clog2(WIDTH)  current digit position, 0 = LSB
- word_pos  out  WSEL_W  current word position
- word_start  out  1  high when bit_pos == 0
- sign_q  out  1  last sampled sign bit
- sign_valid  out  1  one-cycle pulse when sign_q updated

## Operation

- Store: WORDS×WIDTH-bit shift register; store_out = oldest bit. Counters bit_pos (wraps WIDTH-1→0) and word_pos (increments on bit wrap, wraps WORDS-1→0) identify store_out.
- sel = (word_pos == word_sel); forced 1 when WORDS = 1. word_sel ≥ WORDS: sel never true.
- ppi (= tap):
  - sel=0: store_out (unconditional recirculation).
  - sel=1: (store_out & recirc) | (din & load). load and recirc together → bitwise OR (superposition). recirc=0, load=0 → zero written (clear).
- Written bit:
  - shift=0 or sel=0: ppi.
  - shift=1 and sel=1: ppi_d (ppi of previous clock); at bit_pos=0 forced 0. MSB of the word is discarded; no spill into the adjacent word.
- dout = ppi & out_en & sel (combinational).
- Sign test: at bit_pos = WIDTH-1 with sel & sign_req, sign_q <= ppi and sign_valid <= 1 next cycle; otherwise sign_valid <= 0. sign_q holds until the next sample.
- Controls are sampled every clock; a control change mid-word affects only the remaining digits of that word.

## Timing

- Reset (rst_n=0 at rising edge): all store bits, ppi_d, bit_pos, word_pos, sign_q, sign_valid = 0. Hence tap = dout = 0 and word_start = 1 in the cycle after reset. Reset mid-circulation discards all contents in one cycle.
- Recirculation latency: a bit written at cycle t reappears at store_out at t + WORDS×WIDTH. Same bit_pos/word_pos is preserved; with shift, the bit reappears at bit_pos+1.
- dout/tap: zero-latency combinational from din, load, recirc and store_out.
- sign_valid: asserted the cycle after the MSB digit, for exactly 1 cycle.
- No handshake; the controlling unit aligns controls to word_start/word_pos.

## Test plan

- Reset: hold recirc=1, no load, for 2×WORDS×WIDTH cycles after rst_n rises → tap, dout, sign_valid stay 0; word_start pulses every WIDTH cycles.
- Load/recirculate (WIDTH=36, WORDS=1): load serial 0x000000005 over one minor cycle, then recirc=1, out_en=1 → dout reproduces 0x000000005 each 36 cycles for 3 circulations.
- Shift: stored 0x800000003, one circulation with recirc=1, shift=1 → next circulation reads 0x000000006.
- Multi-word (WORDS=4): load words 0..3 with 0x1, 0x2, 0xA, 0x4; then word_sel=1, recirc=0 for one circulation → words read 0x1, 0x0, 0xA, 0x4; other words unchanged.
- Superposition and sign: stored 0x3, recirc=1, load=1 with din 0x4 → 0x7. Stored 0x800000000 with sign_req → sign_valid one cycle after bit 35, sign_q=1. With 0x7 stored, sign_q=0.
- Reset mid-operation: assert rst_n=0 at bit_pos=17 of a loaded word → next cycle bit_pos=0, and all words read 0 thereafter.
